// File: rtl/apb_i2c_pkg.sv
// Shared constants and types for the APB front end of the I2C controller.
// Holds the register address map, bus/byte widths and the APB phase FSM encoding.
package apb_i2c_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned ByteWidth = 8;

    localparam logic [DataWidth-1:0] AddrCtrl = 32'h0000_0000;
    localparam logic [DataWidth-1:0] AddrStat = 32'h0000_0004;
    localparam logic [DataWidth-1:0] AddrData = 32'hFF00_0000;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// APB slave exposing the I2C control, status and data registers.
// Address decode, phase FSM and register bank are kept inline.
module apb_slave
    import apb_i2c_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWrite,
    input  logic [DataWidth-1:0] PADDR,
    input  logic [DataWidth-1:0] PWDATA,
    input  logic [DataWidth-1:0] Dout,
    input  logic                 ready,
    input  logic [ByteWidth-1:0] i2c_stat,
    output logic [ByteWidth-1:0] i2c_con1,
    output logic [ByteWidth-1:0] i2c_con2,
    output logic [DataWidth-1:0] PRDATA,
    output logic [DataWidth-1:0] Din,
    output logic                 PREADY,
    output logic                 PSLVERR
);

    apb_state_e           state_q, state_d;
    logic [ByteWidth-1:0] con1_q, con1_d;
    logic [ByteWidth-1:0] con2_q, con2_d;
    logic [DataWidth-1:0] din_q, din_d;

    logic access, sel_ctrl, sel_stat, sel_data, unmapped;
    logic proto_err, err, pready;

    // Outputs are gated by PRESETn so they read 0 for the whole reset interval.
    always_comb begin
        access    = PRESETn & PSEL & PENABLE;
        sel_ctrl  = (PADDR == AddrCtrl);
        sel_stat  = (PADDR == AddrStat);
        sel_data  = (PADDR == AddrData);
        unmapped  = ~(sel_ctrl | sel_stat | sel_data);
        proto_err = access && (state_q == StIdle);

        if (!access) begin
            pready = 1'b0;
        end else if (proto_err || !sel_data) begin
            pready = 1'b1;
        end else begin
            pready = ready;
        end

        err = proto_err | unmapped | (sel_stat & PWrite);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) state_d = StSetup;
            end
            StSetup: begin
                // A zero-wait transfer finishes here; only a stalled one parks in StAccess.
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (PENABLE) begin
                    state_d = pready ? StIdle : StAccess;
                end
            end
            StAccess: begin
                if (PSEL && PENABLE) begin
                    if (pready) state_d = StIdle;
                end else if (PSEL) begin
                    state_d = StSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        con1_d = con1_q;
        con2_d = con2_q;
        din_d  = din_q;
        if (pready && PWrite && !err) begin
            if (sel_ctrl) begin
                con1_d = PWDATA[7:0];
                con2_d = PWDATA[15:8];
            end
            if (sel_data) din_d = PWDATA;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (pready && !PWrite && !err) begin
            if (sel_ctrl) begin
                PRDATA = {16'h0, con2_q, con1_q};
            end else if (sel_stat) begin
                PRDATA = {24'h0, i2c_stat};
            end else begin
                PRDATA = Dout;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
            con1_q  <= '0;
            con2_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            con1_q  <= con1_d;
            con2_q  <= con2_d;
            din_q   <= din_d;
        end
    end

    assign PREADY   = pready;
    assign PSLVERR  = pready & err;
    assign i2c_con1 = con1_q;
    assign i2c_con2 = con2_q;
    assign Din      = din_q;

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: directed scenarios with literal expectations
// followed by randomized APB traffic compared against a transaction-level model.
module tb_apb_slave;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWrite;
    logic [31:0] PADDR, PWDATA, Dout;
    logic        ready;
    logic [7:0]  i2c_stat;
    logic [7:0]  i2c_con1, i2c_con2;
    logic [31:0] PRDATA, Din;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_slave dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWrite   (PWrite),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .Dout     (Dout),
        .ready    (ready),
        .i2c_stat (i2c_stat),
        .i2c_con1 (i2c_con1),
        .i2c_con2 (i2c_con2),
        .PRDATA   (PRDATA),
        .Din      (Din),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Reference model: register contents plus whether the next access phase is legal
    // (it is legal only right after a setup phase or a stalled access phase).
    logic [7:0]  m_con1  = 8'h0;
    logic [7:0]  m_con2  = 8'h0;
    logic [31:0] m_din   = 32'h0;
    logic        m_armed = 1'b0;

    function automatic logic m_mapped();
        return PADDR == 32'h0 || PADDR == 32'h4 || PADDR == 32'hFF00_0000;
    endfunction

    function automatic logic m_ready();
        if (PRESETn !== 1'b1 || !(PSEL && PENABLE)) return 1'b0;
        if (!m_armed) return 1'b1;
        if (PADDR == 32'hFF00_0000) return ready;
        return 1'b1;
    endfunction

    function automatic logic m_err();
        return m_ready() && (!m_armed || !m_mapped() || (PADDR == 32'h4 && PWrite));
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!m_ready() || PWrite || m_err()) return 32'h0;
        if (PADDR == 32'h0) return {16'h0, m_con2, m_con1};
        if (PADDR == 32'h4) return {24'h0, i2c_stat};
        return Dout;
    endfunction

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_con1  <= 8'h0;
            m_con2  <= 8'h0;
            m_din   <= 32'h0;
            m_armed <= 1'b0;
        end else begin
            if (m_ready() && !m_err() && PWrite) begin
                if (PADDR == 32'h0) begin
                    m_con1 <= PWDATA[7:0];
                    m_con2 <= PWDATA[15:8];
                end else if (PADDR == 32'hFF00_0000) begin
                    m_din <= PWDATA;
                end
            end
            m_armed <= (PSEL && !PENABLE) || (PSEL && PENABLE && m_armed && !m_ready());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs settle mid-cycle, well away from the rising edge.
    always @(negedge PCLK) begin
        chk("PREADY", 32'(PREADY), 32'(m_ready()));
        chk("PSLVERR", 32'(PSLVERR), 32'(m_err()));
        chk("PRDATA", PRDATA, m_rdata());
        chk("i2c_con1", 32'(i2c_con1), 32'(m_con1));
        chk("i2c_con2", 32'(i2c_con2), 32'(m_con2));
        chk("Din", Din, m_din);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apply(input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        PSEL    = sel;
        PENABLE = en;
        PWrite  = wr;
        PADDR   = addr;
        PWDATA  = wd;
    endtask

    task automatic lit_regs(input string tag, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [31:0] d);
        chk({tag, "_con1"}, 32'(i2c_con1), 32'(c1));
        chk({tag, "_con2"}, 32'(i2c_con2), 32'(c2));
        chk({tag, "_din"}, Din, d);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'h4;
            2: return 32'hFF00_0000;
            default: return 32'h8 + 32'($urandom_range(0, 63)) * 4;
        endcase
    endfunction

    initial begin
        logic [31:0] a, wd;
        logic        wr;
        int          waits;

        PRESETn = 1'b0;
        apply(0, 0, 0, 32'h0, 32'h0);
        ready = 1'b0;
        Dout = 32'h0;
        i2c_stat = 8'h0;
        tick();
        tick();
        lit_regs("reset", 8'h0, 8'h0, 32'h0);
        chk("reset_pready", 32'(PREADY), 32'h0);
        PRESETn = 1'b1;
        tick();

        // CTRL write, then back-to-back DATA write
        apply(1, 0, 1, 32'h0, 32'h0000_C61F);
        ready = 1'b1;
        tick();
        apply(1, 1, 1, 32'h0, 32'h0000_C61F);
        @(negedge PCLK);
        chk("ctrl_wr_pready", 32'(PREADY), 32'h1);
        tick();
        lit_regs("ctrl_wr", 8'h1F, 8'hC6, 32'h0);
        apply(1, 0, 1, 32'hFF00_0000, 32'hF03B_0000);
        tick();
        apply(1, 1, 1, 32'hFF00_0000, 32'hF03B_0000);
        tick();
        lit_regs("data_wr", 8'h1F, 8'hC6, 32'hF03B_0000);

        // Stalled DATA write
        apply(1, 0, 1, 32'hFF00_0000, 32'hBB2E_0FF0);
        tick();
        apply(1, 1, 1, 32'hFF00_0000, 32'hBB2E_0FF0);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("stall_pready", 32'(PREADY), 32'h0);
            tick();
            chk("stall_din", Din, 32'hF03B_0000);
        end
        ready = 1'b1;
        @(negedge PCLK);
        chk("unstall_pready", 32'(PREADY), 32'h1);
        tick();
        chk("unstall_din", Din, 32'hBB2E_0FF0);

        // STAT and DATA reads
        apply(0, 0, 0, 32'h0, 32'h0);
        tick();
        i2c_stat = 8'hA5;
        apply(1, 0, 0, 32'h4, 32'h0);
        tick();
        apply(1, 1, 0, 32'h4, 32'h0);
        @(negedge PCLK);
        chk("stat_rd", PRDATA, 32'h0000_00A5);
        tick();
        Dout = 32'h1234_5678;
        apply(1, 0, 0, 32'hFF00_0000, 32'h0);
        tick();
        apply(1, 1, 0, 32'hFF00_0000, 32'h0);
        @(negedge PCLK);
        chk("data_rd", PRDATA, 32'h1234_5678);
        tick();

        // Unmapped write and STAT write both error out
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 32'h8 : 32'h4;
            apply(1, 0, 1, a, 32'hFFFF_FFFF);
            tick();
            apply(1, 1, 1, a, 32'hFFFF_FFFF);
            @(negedge PCLK);
            chk("err_pready", 32'(PREADY), 32'h1);
            chk("err_pslverr", 32'(PSLVERR), 32'h1);
            tick();
            lit_regs("err_wr", 8'h1F, 8'hC6, 32'hBB2E_0FF0);
        end

        // Access phase with no preceding setup
        apply(0, 0, 0, 32'h0, 32'h0);
        tick();
        apply(1, 1, 1, 32'h0, 32'h0000_FFFF);
        @(negedge PCLK);
        chk("proto_pslverr", 32'(PSLVERR), 32'h1);
        tick();
        lit_regs("proto", 8'h1F, 8'hC6, 32'hBB2E_0FF0);

        // Reset during a stalled DATA access, then access without fresh setup
        apply(1, 0, 1, 32'hFF00_0000, 32'h1111_1111);
        tick();
        apply(1, 1, 1, 32'hFF00_0000, 32'h1111_1111);
        ready = 1'b0;
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        lit_regs("midrst", 8'h0, 8'h0, 32'h0);
        chk("midrst_pready", 32'(PREADY), 32'h0);
        tick();
        tick();
        PRESETn = 1'b1;
        ready = 1'b1;
        @(negedge PCLK);
        chk("postrst_pslverr", 32'(PSLVERR), 32'h1);
        tick();
        chk("postrst_din", Din, 32'h0);
        apply(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            a  = rand_addr();
            wd = $urandom;
            wr = 1'($urandom_range(0, 1));
            Dout = $urandom;
            i2c_stat = 8'($urandom);
            ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 19))
                0: begin
                    apply(1, 1, wr, a, wd);
                    tick();
                end
                1: begin
                    apply(1, 0, wr, a, wd);
                    tick();
                    apply(1, 1, wr, a, wd);
                    ready = 1'b0;
                    @(negedge PCLK);
                    #2 PRESETn = 1'b0;
                    tick();
                    PRESETn = 1'b1;
                end
                default: begin
                    waits = (a == 32'hFF00_0000) ? $urandom_range(0, 3) : 0;
                    apply(1, 0, wr, a, wd);
                    tick();
                    for (int w = 0; w <= waits; w++) begin
                        if (a == 32'hFF00_0000) ready = (w == waits);
                        Dout = $urandom;
                        apply(1, 1, wr, a, wd);
                        tick();
                    end
                end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                apply(0, 0, 0, 32'h0, 32'h0);
                tick();
            end
        end

        apply(0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL provide: PCLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: PRESETn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: PSEL  in  1  APB select.
REQ-004 SHALL provide: PENABLE  in  1  APB access phase.
REQ-005 SHALL provide: PWrite  in  1  1=write, 0=read.
REQ-006 SHALL provide: PADDR  in  32  byte address.
REQ-007 SHALL provide: PWDATA  in  32  write data.
REQ-008 SHALL provide: Dout  in  32  receive data from I2C core.
REQ-009 SHALL provide: ready  in  1  I2C core able to accept/return data.
REQ-010 SHALL provide: i2c_stat  in  8  I2C status byte.
REQ-011 SHALL provide: i2c_con1  out  8  control reg 1 (ff, R, D/A, cc, e, r fields; opaque to this block).
REQ-012 SHALL provide: i2c_con2  out  8  control reg 2 ([7:1] slave addr, [0] r/w).
REQ-013 SHALL provide: PRDATA  out  32  read data.
REQ-014 SHALL provide: Din  out  32  transmit data to I2C core.
REQ-015 SHALL provide: PREADY  out  1  transfer completion.
REQ-016 SHALL provide: PSLVERR  out  1  transfer error.

Function
REQ-017 Address map SHALL be: CTRL 0x0000_0000 RW; STAT 0x0000_0004 RO; DATA 0xFF00_0000 RW; all other addresses unmapped.
REQ-018 FSM SHALL have states IDLE, SETUP, ACCESS: IDLE->SETUP on PSEL&!PENABLE; SETUP->ACCESS on PSEL&PENABLE; ACCESS->IDLE (or SETUP if PSEL&!PENABLE) when PREADY=1; ACCESS holds while PREADY=0.
REQ-019 PREADY SHALL be combinational: 1 in ACCESS-phase (PSEL&PENABLE) when target is CTRL, STAT or unmapped; equal to ready when target is DATA; 0 outside access phase.
REQ-020 Transfer SHALL complete on the rising edge where PSEL&PENABLE&PREADY=1; register writes commit only on that edge.
REQ-021 CTRL write SHALL load i2c_con1<=PWDATA[7:0], i2c_con2<=PWDATA[15:8]; PWDATA[31:16] ignored.
REQ-022 CTRL read SHALL return {16'h0, i2c_con2, i2c_con1}.
REQ-023 STAT read SHALL return {24'h0, i2c_stat}; STAT write SHALL assert PSLVERR with no side effect.
REQ-024 DATA write SHALL load Din<=PWDATA (full 32 bits); DATA read SHALL return Dout.
REQ-025 Unmapped access SHALL complete with PSLVERR=1, PRDATA=0, no register change.
REQ-026 PRDATA SHALL be combinational, valid when PSEL&PENABLE&!PWrite&PREADY, else 0.
REQ-027 PSLVERR SHALL be 0 except during a completing access phase (PREADY=1) that is in error.
REQ-028 PENABLE=1 while in IDLE (no setup phase) SHALL be treated as a protocol error: PREADY=1, PSLVERR=1, no write.
REQ-029 Address, PWrite and PWDATA SHALL be sampled at the completing edge, not latched in SETUP.

Reset
REQ-030 PRESETn=0 SHALL immediately clear i2c_con1, i2c_con2, Din to 0, FSM to IDLE; PREADY, PSLVERR, PRDATA read 0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no write committed; first transfer after release requires a fresh SETUP.

Structure
REQ-032 Package apb_i2c_pkg SHALL hold the three address constants, the FSM state type and the 32/8-bit width constants.
REQ-033 Single module; no sub-module required (decode, FSM and register bank inline).

Verification
REQ-034 Reset release, write CTRL PWDATA=0x0000_C61F, ready=1 -> PREADY=1 in access phase; i2c_con1=0x1F, i2c_con2=0xC6, Din=0.
REQ-035 Back-to-back write DATA PWDATA=0xF03B_0000, ready=1 -> Din=0xF03B_0000 after one access cycle; con regs unchanged.
REQ-036 Assert PRESETn=0 during a DATA access phase -> i2c_con1, i2c_con2, Din=0 immediately, FSM IDLE.
REQ-037 Write DATA PWDATA=0xBB2E_0FF0 with ready=0 -> PREADY=0, Din unchanged for 3 cycles; raise ready -> PREADY=1, Din=0xBB2E_0FF0 on that edge.
REQ-038 Read STAT with i2c_stat=0xA5 -> PRDATA=0x0000_00A5; read DATA with Dout=0x1234_5678, ready=1 -> PRDATA=0x1234_5678.
REQ-039 Write 0x0000_0008 and write STAT -> PREADY=1, PSLVERR=1, all registers unchanged.
